seq_ctrl: RTL and testbench



---
 rtl/seq_ctrl_pkg.sv | 58 +++++
 rtl/seq_ctrl_decode.sv | 105 ++++++++++
 rtl/seq_ctrl.sv | 64 ++++++
 tb/tb_seq_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: state encodings, datapath select codes and instruction constants for seq_ctrl
package seq_ctrl_pkg;
  typedef enum logic [4:0] {
    S_RESET    = 5'd0,
    S_FETCH    = 5'd1,
    S_FETCH_W  = 5'd2,
    S_IR       = 5'd3,
    S_DECODE   = 5'd4,
    S_RTYPE    = 5'd5,
    S_RTYPE_WB = 5'd6,
    S_ADDI     = 5'd7,
    S_ADDI_WB  = 5'd8,
    S_MEMADDR  = 5'd9,
    S_LW_RD    = 5'd10,
    S_LW_W     = 5'd11,
    S_LW_WB    = 5'd12,
    S_SW       = 5'd13,
    S_BEQ      = 5'd14,
    S_JUMP     = 5'd15,
    S_EXC_OPC  = 5'd16,
    S_EXC_OVF  = 5'd17,
    S_EXC_W    = 5'd18,
    S_EXC_LD   = 5'd19
  } state_t;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;
  localparam logic [2:0] PCS_ALU = 3'b000;
  localparam logic [2:0] PCS_ALUOUT = 3'b001;
  localparam logic [2:0] PCS_JUMP = 3'b010;
  localparam logic [2:0] PCS_EXC = 3'b011;
  localparam logic [2:0] IORD_PC = 3'b000;
  localparam logic [2:0] IORD_ALUOUT = 3'b001;
  localparam logic [2:0] IORD_253 = 3'b010;
  localparam logic [2:0] IORD_254 = 3'b011;
  localparam logic [1:0] SRCB_B = 2'b00;
  localparam logic [1:0] SRCB_4 = 2'b01;
  localparam logic [1:0] SRCB_SE16 = 2'b10;
  localparam logic [1:0] SRCB_SL2 = 2'b11;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  function automatic state_t dispatch(input logic [5:0] op);
    return op == OP_RTYPE ? S_RTYPE :
           op == OP_ADDI ? S_ADDI :
           (op == OP_LW || op == OP_SW) ? S_MEMADDR :
           op == OP_BEQ ? S_BEQ :
           op == OP_J ? S_JUMP : S_EXC_OPC;
  endfunction
endpackage

// File: rtl/seq_ctrl_decode.sv
// seq_ctrl_decode: state to control-output decode for the multicycle controller
module seq_ctrl_decode
  import seq_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] FUNCT,
  input  logic       Eq,
  input  logic       exc_ovf,
  output logic       PC_write,
  output logic       MEM_write,
  output logic       IR_write,
  output logic       AB_write,
  output logic       Regwrite,
  output logic       ALUOutCtrl,
  output logic       EPC_write,
  output logic       MDR_write,
  output logic [2:0] Alu_control,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       M_writeReg,
  output logic [3:0] MEMtoReg,
  output logic [2:0] PCsource,
  output logic [2:0] IorD
);
  always_comb begin
    {PC_write, MEM_write, IR_write, AB_write, Regwrite, ALUOutCtrl, EPC_write, MDR_write} = '0;
    Alu_control = ALU_PASS;
    AluSrcA = 1'b0;
    AluSrcB = SRCB_B;
    M_writeReg = 1'b0;
    MEMtoReg = 4'd0;
    PCsource = PCS_ALU;
    IorD = IORD_PC;
    case (state)
      S_FETCH, S_FETCH_W: begin
        AluSrcB = SRCB_4;
        Alu_control = ALU_ADD;
      end
      S_IR: begin
        AluSrcB = SRCB_4;
        Alu_control = ALU_ADD;
        IR_write = 1'b1;
        PC_write = 1'b1;
      end
      S_DECODE: begin
        AB_write = 1'b1;
        ALUOutCtrl = 1'b1;
        AluSrcB = SRCB_SL2;
        Alu_control = ALU_ADD;
      end
      S_RTYPE: begin
        AluSrcA = 1'b1;
        ALUOutCtrl = 1'b1;
        Alu_control = FUNCT == FN_ADD ? ALU_ADD : FUNCT == FN_SUB ? ALU_SUB :
                      FUNCT == FN_AND ? ALU_AND : ALU_PASS;
      end
      S_ADDI, S_MEMADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = SRCB_SE16;
        Alu_control = ALU_ADD;
        ALUOutCtrl = 1'b1;
      end
      S_RTYPE_WB: begin
        Regwrite = 1'b1;
        M_writeReg = 1'b1;
      end
      S_ADDI_WB: Regwrite = 1'b1;
      S_LW_RD: IorD = IORD_ALUOUT;
      S_LW_W: begin
        IorD = IORD_ALUOUT;
        MDR_write = 1'b1;
      end
      S_LW_WB: begin
        Regwrite = 1'b1;
        MEMtoReg = 4'd1;
      end
      S_SW: begin
        IorD = IORD_ALUOUT;
        MEM_write = 1'b1;
      end
      S_BEQ: begin
        AluSrcA = 1'b1;
        Alu_control = ALU_CMP;
        PCsource = PCS_ALUOUT;
        PC_write = Eq;
      end
      S_JUMP: begin
        PCsource = PCS_JUMP;
        PC_write = 1'b1;
      end
      S_EXC_OPC, S_EXC_OVF: begin
        AluSrcB = SRCB_4;
        Alu_control = ALU_SUB;
        EPC_write = 1'b1;
        IorD = state == S_EXC_OVF ? IORD_254 : IORD_253;
      end
      S_EXC_W: IorD = exc_ovf ? IORD_254 : IORD_253;
      S_EXC_LD: begin
        PCsource = PCS_EXC;
        PC_write = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multicycle control FSM; next-state here, output decode in seq_ctrl_decode
module seq_ctrl
  import seq_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Overflow,
  input  logic       Eq,
  output logic       PC_write,
  output logic       MEM_write,
  output logic       IR_write,
  output logic       AB_write,
  output logic       Regwrite,
  output logic       ALUOutCtrl,
  output logic       EPC_write,
  output logic       MDR_write,
  output logic [2:0] Alu_control,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       M_writeReg,
  output logic [3:0] MEMtoReg,
  output logic [2:0] PCsource,
  output logic [2:0] IorD,
  output logic [4:0] state_out
);
  state_t state;
  logic exc_ovf;
  // exc_ovf remembers which trap entered S_EXC_W so the vector address is held
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_RESET;
      exc_ovf <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_FETCH_W;
        S_FETCH_W: state <= S_IR;
        S_IR: state <= S_DECODE;
        S_DECODE: state <= dispatch(OPCODE);
        S_RTYPE: state <= !(FUNCT == FN_ADD || FUNCT == FN_SUB || FUNCT == FN_AND) ? S_EXC_OPC :
                          (Overflow && FUNCT != FN_AND) ? S_EXC_OVF : S_RTYPE_WB;
        S_ADDI: state <= Overflow ? S_EXC_OVF : S_ADDI_WB;
        S_MEMADDR: state <= OPCODE == OP_LW ? S_LW_RD : OPCODE == OP_SW ? S_SW : S_EXC_OPC;
        S_LW_RD: state <= S_LW_W;
        S_LW_W: state <= S_LW_WB;
        S_EXC_OPC, S_EXC_OVF: begin
          state <= S_EXC_W;
          exc_ovf <= state == S_EXC_OVF;
        end
        S_EXC_W: state <= S_EXC_LD;
        default: state <= S_FETCH;
      endcase
    end
  end
  assign state_out = state;
  seq_ctrl_decode u_decode (
    .state(state), .FUNCT(FUNCT), .Eq(Eq), .exc_ovf(exc_ovf),
    .PC_write(PC_write), .MEM_write(MEM_write), .IR_write(IR_write), .AB_write(AB_write),
    .Regwrite(Regwrite), .ALUOutCtrl(ALUOutCtrl), .EPC_write(EPC_write), .MDR_write(MDR_write),
    .Alu_control(Alu_control), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .M_writeReg(M_writeReg),
    .MEMtoReg(MEMtoReg), .PCsource(PCsource), .IorD(IorD)
  );
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: scoreboard bench walking seq_ctrl through every instruction class and mid-instruction resets
module tb_seq_ctrl;
  import seq_ctrl_pkg::*;
  logic clock = 1'b0, reset = 1'b1;
  logic [5:0] OPCODE = 6'h00, FUNCT = 6'h00;
  logic Overflow = 1'b0, Eq = 1'b0;
  logic PC_write, MEM_write, IR_write, AB_write, Regwrite, ALUOutCtrl, EPC_write, MDR_write;
  logic [2:0] Alu_control, PCsource, IorD;
  logic AluSrcA, M_writeReg;
  logic [1:0] AluSrcB;
  logic [3:0] MEMtoReg;
  logic [4:0] state_out;
  int checks = 0, failures = 0;
  typedef struct {
    string tag;
    logic [4:0] st;
    logic [7:0] strb;
    logic [16:0] mux;
  } exp_t;
  exp_t q[$];
  seq_ctrl dut (
    .clock(clock), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Overflow(Overflow), .Eq(Eq),
    .PC_write(PC_write), .MEM_write(MEM_write), .IR_write(IR_write), .AB_write(AB_write),
    .Regwrite(Regwrite), .ALUOutCtrl(ALUOutCtrl), .EPC_write(EPC_write), .MDR_write(MDR_write),
    .Alu_control(Alu_control), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .M_writeReg(M_writeReg),
    .MEMtoReg(MEMtoReg), .PCsource(PCsource), .IorD(IorD), .state_out(state_out)
  );
  always #5 clock = ~clock;
  // {AluSrcA, AluSrcB, Alu_control, M_writeReg, MEMtoReg, PCsource, IorD}
  function automatic logic [16:0] mx(input logic a, input logic [1:0] b, input logic [2:0] alu,
                                     input logic w, input logic [3:0] m, input logic [2:0] p,
                                     input logic [2:0] i);
    return {a, b, alu, w, m, p, i};
  endfunction
  task automatic push(input string tag, input state_t s, input logic [7:0] strb, input logic [16:0] m);
    q.push_back('{tag, s, strb, m});
  endtask
  task automatic chk();
    exp_t e;
    logic [7:0] strb;
    logic [16:0] m;
    e = q.pop_front();
    strb = {PC_write, MEM_write, IR_write, AB_write, Regwrite, ALUOutCtrl, EPC_write, MDR_write};
    m = {AluSrcA, AluSrcB, Alu_control, M_writeReg, MEMtoReg, PCsource, IorD};
    checks++;
    assert (state_out === e.st) else begin
      failures++;
      $error("FAIL %s state: got %0d expected %0d", e.tag, state_out, e.st);
    end
    checks++;
    assert (strb === e.strb) else begin
      failures++;
      $error("FAIL %s strobes: got %b expected %b", e.tag, strb, e.strb);
    end
    checks++;
    assert (m === e.mux) else begin
      failures++;
      $error("FAIL %s selects: got %b expected %b", e.tag, m, e.mux);
    end
  endtask
  task automatic drain();
    while (q.size() > 0) begin
      @(posedge clock);
      #1;
      chk();
    end
  endtask
  task automatic start(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic ov, input logic eq);
    OPCODE = op;
    FUNCT = fn;
    Overflow = ov;
    Eq = eq;
    push({tag, ".fetch"}, S_FETCH, 8'b0000_0000, mx(0, 2'b01, 3'b001, 0, 0, 0, 0));
    push({tag, ".fetch_w"}, S_FETCH_W, 8'b0000_0000, mx(0, 2'b01, 3'b001, 0, 0, 0, 0));
    push({tag, ".ir"}, S_IR, 8'b1010_0000, mx(0, 2'b01, 3'b001, 0, 0, 0, 0));
    push({tag, ".decode"}, S_DECODE, 8'b0001_0100, mx(0, 2'b11, 3'b001, 0, 0, 0, 0));
  endtask
  task automatic exc_tail(input string tag, input logic ovf);
    logic [2:0] v;
    v = ovf ? 3'b011 : 3'b010;
    push({tag, ".exc"}, ovf ? S_EXC_OVF : S_EXC_OPC, 8'b0000_0010, mx(0, 2'b01, 3'b010, 0, 0, 0, v));
    push({tag, ".exc_w"}, S_EXC_W, 8'b0000_0000, mx(0, 0, 0, 0, 0, 0, v));
    push({tag, ".exc_ld"}, S_EXC_LD, 8'b1000_0000, mx(0, 0, 0, 0, 0, 3'b011, 0));
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    push("reset", S_RESET, 8'b0, 17'b0);
    chk();
    reset = 1'b0;
    start("radd", 6'h00, 6'h20, 0, 0);
    push("radd.ex", S_RTYPE, 8'b0000_0100, mx(1, 2'b00, 3'b001, 0, 0, 0, 0));
    push("radd.wb", S_RTYPE_WB, 8'b0000_1000, mx(0, 0, 0, 1, 0, 0, 0));
    drain();
    start("raddovf", 6'h00, 6'h20, 1, 0);
    push("raddovf.ex", S_RTYPE, 8'b0000_0100, mx(1, 2'b00, 3'b001, 0, 0, 0, 0));
    exc_tail("raddovf", 1);
    drain();
    start("rsubovf", 6'h00, 6'h22, 1, 0);
    push("rsubovf.ex", S_RTYPE, 8'b0000_0100, mx(1, 2'b00, 3'b010, 0, 0, 0, 0));
    exc_tail("rsubovf", 1);
    drain();
    start("rand", 6'h00, 6'h24, 1, 0);
    push("rand.ex", S_RTYPE, 8'b0000_0100, mx(1, 2'b00, 3'b011, 0, 0, 0, 0));
    push("rand.wb", S_RTYPE_WB, 8'b0000_1000, mx(0, 0, 0, 1, 0, 0, 0));
    drain();
    start("rbadfn", 6'h00, 6'h2A, 0, 0);
    push("rbadfn.ex", S_RTYPE, 8'b0000_0100, mx(1, 2'b00, 3'b000, 0, 0, 0, 0));
    exc_tail("rbadfn", 0);
    drain();
    start("addi", 6'h08, 6'h00, 0, 0);
    push("addi.ex", S_ADDI, 8'b0000_0100, mx(1, 2'b10, 3'b001, 0, 0, 0, 0));
    push("addi.wb", S_ADDI_WB, 8'b0000_1000, mx(0, 0, 0, 0, 0, 0, 0));
    drain();
    start("addiovf", 6'h08, 6'h00, 1, 0);
    push("addiovf.ex", S_ADDI, 8'b0000_0100, mx(1, 2'b10, 3'b001, 0, 0, 0, 0));
    exc_tail("addiovf", 1);
    drain();
    start("lw", 6'h23, 6'h00, 1, 1);
    push("lw.addr", S_MEMADDR, 8'b0000_0100, mx(1, 2'b10, 3'b001, 0, 0, 0, 0));
    push("lw.rd", S_LW_RD, 8'b0000_0000, mx(0, 0, 0, 0, 0, 0, 3'b001));
    push("lw.w", S_LW_W, 8'b0000_0001, mx(0, 0, 0, 0, 0, 0, 3'b001));
    push("lw.wb", S_LW_WB, 8'b0000_1000, mx(0, 0, 0, 0, 4'd1, 0, 0));
    drain();
    start("sw", 6'h2B, 6'h00, 0, 0);
    push("sw.addr", S_MEMADDR, 8'b0000_0100, mx(1, 2'b10, 3'b001, 0, 0, 0, 0));
    push("sw.wr", S_SW, 8'b0100_0000, mx(0, 0, 0, 0, 0, 0, 3'b001));
    drain();
    start("beq1", 6'h04, 6'h00, 1, 1);
    push("beq1.br", S_BEQ, 8'b1000_0000, mx(1, 2'b00, 3'b111, 0, 0, 3'b001, 0));
    drain();
    start("beq0", 6'h04, 6'h00, 0, 0);
    push("beq0.br", S_BEQ, 8'b0000_0000, mx(1, 2'b00, 3'b111, 0, 0, 3'b001, 0));
    drain();
    start("j", 6'h02, 6'h00, 0, 1);
    push("j.jmp", S_JUMP, 8'b1000_0000, mx(0, 0, 0, 0, 0, 3'b010, 0));
    drain();
    start("badop", 6'h3F, 6'h00, 0, 0);
    exc_tail("badop", 0);
    drain();
    start("swrst", 6'h2B, 6'h00, 0, 0);
    push("swrst.addr", S_MEMADDR, 8'b0000_0100, mx(1, 2'b10, 3'b001, 0, 0, 0, 0));
    push("swrst.wr", S_SW, 8'b0100_0000, mx(0, 0, 0, 0, 0, 0, 3'b001));
    drain();
    reset = 1'b1;
    push("swrst.reset", S_RESET, 8'b0, 17'b0);
    drain();
    reset = 1'b0;
    start("excrst", 6'h3F, 6'h00, 0, 0);
    push("excrst.exc", S_EXC_OPC, 8'b0000_0010, mx(0, 2'b01, 3'b010, 0, 0, 0, 3'b010));
    push("excrst.exc_w", S_EXC_W, 8'b0000_0000, mx(0, 0, 0, 0, 0, 0, 3'b010));
    drain();
    reset = 1'b1;
    push("excrst.reset", S_RESET, 8'b0, 17'b0);
    drain();
    reset = 1'b0;
    start("jafter", 6'h02, 6'h00, 0, 0);
    push("jafter.jmp", S_JUMP, 8'b1000_0000, mx(0, 0, 0, 0, 0, 3'b010, 0));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
